// File: rtl/link_control.sv
// rtl/link_control.sv - game-sequencing FSM driving character drawer strobes and map/char redraw
//
// Once per video frame: sample buttons, issue at most one move/attack strobe,
// then run a map redraw followed by a character redraw and return to idle.
//
// Ports:
//   clock_i, reset_i          clock, asynchronous active-high reset
//   btn_*_i                   synchronised player buttons (active-high levels)
//   frame_tick_i              one-cycle pulse per video frame
//   map_done_i, draw_done_i   one-cycle completion pulses from the drawers
//   init_o, idle_o, attack_o, move_*_o   Moore strobes to the character drawer
//   draw_map_o, draw_char_o   drawer run levels
//   draw_err_o                one-cycle pulse after a draw timeout
//   overrun_o                 saturating count of dropped frame ticks
module link_control #(
    parameter int unsigned ATTACK_FRAMES = 16,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       btn_attack_i,
    input  logic       frame_tick_i,
    input  logic       map_done_i,
    input  logic       draw_done_i,
    output logic       init_o,
    output logic       idle_o,
    output logic       attack_o,
    output logic       move_up_o,
    output logic       move_down_o,
    output logic       move_left_o,
    output logic       move_right_o,
    output logic       draw_map_o,
    output logic       draw_char_o,
    output logic       draw_err_o,
    output logic [7:0] overrun_o
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_IDLE   = 3'd2;
    localparam logic [2:0] S_MOVE   = 3'd3;
    localparam logic [2:0] S_ATTACK = 3'd4;
    localparam logic [2:0] S_MAP    = 3'd5;
    localparam logic [2:0] S_CHAR   = 3'd6;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [7:0]  ATTACK_LOAD  = 8'(ATTACK_FRAMES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [7:0]  attack_cnt_q, attack_cnt_d;
    logic        pending_q, pending_d;
    logic [7:0]  overrun_q, overrun_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_q, err_d;
    logic        in_draw;
    logic        timed_out;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        attack_cnt_d = attack_cnt_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        err_d        = 1'b0;

        in_draw   = (state_q == S_MAP) || (state_q == S_CHAR);
        timed_out = in_draw && (tmo_cnt_q == TIMEOUT_LAST);

        // Ticks outside idle are buffered one deep; a tick onto a full
        // buffer is dropped and counted.
        if ((state_q != S_IDLE) && frame_tick_i) begin
            pending_d = 1'b1;
            if (pending_q && (overrun_q != 8'hFF)) begin
                overrun_d = overrun_q + 8'd1;
            end
        end

        case (state_q)
            S_RESET: state_d = S_INIT;
            S_INIT:  state_d = S_MAP;
            S_IDLE: begin
                if (frame_tick_i || pending_q) begin
                    pending_d = 1'b0;
                    if (attack_cnt_q != 8'd0) begin
                        attack_cnt_d = attack_cnt_q - 8'd1;
                        state_d      = S_MAP;
                    end else if (btn_attack_i) begin
                        attack_cnt_d = ATTACK_LOAD;
                        state_d      = S_ATTACK;
                    end else if (btn_up_i ^ btn_down_i) begin
                        dir_d   = btn_up_i ? DIR_UP : DIR_DOWN;
                        state_d = S_MOVE;
                    end else if (btn_left_i ^ btn_right_i) begin
                        dir_d   = btn_left_i ? DIR_LEFT : DIR_RIGHT;
                        state_d = S_MOVE;
                    end else begin
                        state_d = S_MAP;
                    end
                end
            end
            S_MOVE, S_ATTACK: state_d = S_MAP;
            S_MAP: begin
                // done has priority over a coincident timeout
                if (map_done_i) begin
                    state_d = S_CHAR;
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_CHAR: begin
                if (draw_done_i) begin
                    state_d = S_IDLE;
                end else if (timed_out) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_RESET;
        endcase

        // Counter restarts on every entry to a draw state, including MAP->CHAR.
        if (in_draw && (state_d == state_q)) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
            tmo_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_RESET;
            dir_q        <= DIR_UP;
            attack_cnt_q <= 8'd0;
            pending_q    <= 1'b0;
            overrun_q    <= 8'd0;
            tmo_cnt_q    <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            attack_cnt_q <= attack_cnt_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            tmo_cnt_q    <= tmo_cnt_d;
            err_q        <= err_d;
        end
    end

    assign init_o       = (state_q == S_INIT);
    assign idle_o       = (state_q == S_IDLE);
    assign attack_o     = (state_q == S_ATTACK);
    assign move_up_o    = (state_q == S_MOVE) && (dir_q == DIR_UP);
    assign move_down_o  = (state_q == S_MOVE) && (dir_q == DIR_DOWN);
    assign move_left_o  = (state_q == S_MOVE) && (dir_q == DIR_LEFT);
    assign move_right_o = (state_q == S_MOVE) && (dir_q == DIR_RIGHT);
    assign draw_map_o   = (state_q == S_MAP);
    assign draw_char_o  = (state_q == S_CHAR);
    assign draw_err_o   = err_q;
    assign overrun_o    = overrun_q;

endmodule

// File: doc/link_control.md
# link_control

Game-sequencing FSM that drives the character drawer's one-hot state strobes (init, idle, attack, move_*, draw_char) and consumes its draw_done handshake. It sits between the button/input synchroniser and the character and map drawing blocks. Once per video frame it samples the player buttons, issues at most one movement or attack strobe, then sequences a full map redraw followed by a character redraw before returning to idle.

## Interface
- ATTACK_FRAMES, 16: frames during which movement and attack inputs are locked out after an attack; legal range 1..255.
- TIMEOUT, 65535: maximum cycles to wait in a draw state for its done pulse; legal range 1..65535.
- clock  in  1  system clock; one clock domain only.
- reset  in  1  asynchronous, active-high; forces state S_RESET and clears all registers.
- btn_up, btn_down, btn_left, btn_right, btn_attack  in  1 each  synchronised level inputs, active-high.
- frame_tick  in  1  one-cycle pulse per video frame (vsync).
- map_done  in  1  one-cycle pulse from the map drawer.
- draw_done  in  1  one-cycle pulse from the character drawer.
- init, idle, attack, move_up, move_down, move_left, move_right  out  1 each  strobes to the character drawer.
- draw_map  out  1  level; map drawer runs while it is high.
- draw_char  out  1  level; character drawer runs while it is high.
- draw_err  out  1  one-cycle pulse on a draw timeout.
- overrun  out  8  saturating count of frame_tick pulses that were dropped.

## Operation
- All strobes are Moore-decoded from the state register. At most one strobe is high per cycle.
- States and their outputs:
  - S_RESET: all outputs 0.
  - S_INIT: init=1.
  - S_IDLE: idle=1.
  - S_MOVE: exactly one move_* strobe high.
  - S_ATTACK: attack=1.
  - S_MAP: draw_map=1.
  - S_CHAR: draw_char=1.
- Reset values: state S_RESET, every output 0, overrun 0, attack_cnt 0, pending 0, timeout counter 0.
- Boot transitions: S_RESET goes to S_INIT unconditionally. S_INIT goes to S_MAP unconditionally, giving an initial full draw with no button sampling.
- S_IDLE: when frame_tick or pending is set, clear pending and evaluate the buttons (the "frame decision"). Otherwise stay in S_IDLE.
- Frame decision when attack_cnt != 0: decrement attack_cnt, ignore all buttons, go to S_MAP.
- Frame decision when attack_cnt == 0, in priority order:
  - btn_attack: go to S_ATTACK and load attack_cnt = ATTACK_FRAMES-1.
  - up XOR down: go to S_MOVE with move_up or move_down.
  - else left XOR right: go to S_MOVE with move_left or move_right.
  - else: go to S_MAP (redraw only).
- Direction rules: opposite buttons pressed together cancel. Vertical movement wins over horizontal.
- S_MOVE and S_ATTACK last one cycle each, then go to S_MAP.
- S_MAP: go to S_CHAR on the cycle map_done is sampled high.
- S_CHAR: go to S_IDLE on the cycle draw_done is sampled high.
- map_done is ignored outside S_MAP; draw_done is ignored outside S_CHAR.
- Timeout:
  - A 16-bit counter clears on entry to S_MAP or S_CHAR and increments each cycle in those states.
  - When it reaches TIMEOUT-1 without the expected done pulse, go to S_IDLE and pulse draw_err for one cycle.
  - If the done pulse and the timeout occur in the same cycle, done wins and there is no error.
- Frame buffering:
  - A frame_tick arriving in any state other than S_IDLE sets pending (single depth).
  - A frame_tick arriving while pending is already 1 increments overrun, saturating at 255.
  - In S_IDLE, frame_tick and pending together count as one decision; no overrun is counted.
- ATTACK_FRAMES=1 means no lockout: attack_cnt is loaded with 0.
- Reset asserted mid-sequence aborts immediately to S_RESET with all outputs 0. Any in-flight done pulse is lost, and the drawers restart from init.

## Timing
- Let reset deassert before edge 0 (E0 = first clock edge after release; En = n edges later).
- Boot: S_INIT (init=1) during the cycle after E0, and S_MAP (draw_map=1) after E1.
- Frame latency: frame_tick high in S_IDLE, sampled at edge T, gives:
  - move_*/attack high for the cycle after T, and draw_map from T+1.
  - On a redraw-only frame, draw_map from T.
- Done latency: map_done sampled at edge M gives draw_char=1 in the cycle after M. draw_done sampled at edge D gives idle=1 in the cycle after D.
- Minimum frame cost with both dones returned after one cycle: 4 cycles from frame_tick to S_IDLE for a move frame, 3 for a redraw-only frame.
- Buttons are sampled only at the decision edge; changes at other times have no effect.
- Timeout: with TIMEOUT=N, draw_err is high in the N+1th cycle after entering the draw state, with idle=1 in the same cycle.

## Test plan
- Reset release: init high for exactly 1 cycle at E0+1. With map_done at E3 and draw_done at E5, idle=1 from E6 and overrun=0.
- Move frame: btn_up=1, btn_right=1, then frame_tick. Required: move_up for 1 cycle, no move_right, then draw_map, then draw_char, then idle.
- Opposite buttons: btn_left=1 and btn_right=1 with frame_tick. Required: no move_* strobe and draw_map the cycle after the tick.
- Attack lockout, ATTACK_FRAMES=3, btn_attack plus btn_down held:
  - frame 1: attack strobe;
  - frames 2 and 3: no strobe, redraw only;
  - frame 4: attack again.
- Buffering: three frame_ticks while in S_CHAR. Required: pending=1, overrun=2, and exactly one decision made after draw_done.
- Timeout, TIMEOUT=8, draw_done withheld. Required: draw_err for 1 cycle and idle the same cycle. A late draw_done in S_IDLE is ignored. Reset asserted mid-S_MAP gives all outputs 0 asynchronously.
